change_event_tx: RTL and testbench
==================================

# change_event_tx

Transmit side of the sensor change-alert path. Accepts one change event per clock from the sensor co-processor: a strobe, the 2-bit channel that moved and its new 8-bit reading. Events are queued in a small FIFO and each one is serialised as a framed, parity-protected word on a single output pin for an off-chip monitor. Overflow is reported rather than stalling the producer, which has no back-pressure input.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- BAUD_DIV, 16: clock cycles per serial bit; must be ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset; one clock domain, no other clocks.
- evt_valid  in  1  change event strobe; one event per high cycle.
- evt_chan  in  2  channel index of the event; sampled when evt_valid=1.
- evt_data  in  8  new channel value; sampled when evt_valid=1.
- clr_ovf  in  1  synchronous clear of overflow.
- tx  out  1  serial line; idle high.
- busy  out  1  high while a frame is on the line.
- fifo_full  out  1  high when level == DEPTH.
- level  out  $clog2(DEPTH)+1  entries currently queued.
- overflow  out  1  sticky: an event was dropped.

## Operation
- Reset values: tx=1, busy=0, fifo_full=0, level=0, overflow=0.
- Reset also empties the FIFO and puts the FSM in IDLE.
- Push rule:
  - Each cycle with evt_valid=1 writes {evt_chan, evt_data} into the FIFO if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow is set.
- Overflow clear: clr_ovf=1 clears overflow. If a drop and clr_ovf happen in the same cycle, set wins (overflow=1).
- Level update: push-only gives +1, pop-only gives −1, push and pop together leave it unchanged.
- FIFO pointers wrap modulo DEPTH.
- Frame format, 13 bits, each held BAUD_DIV cycles, sent in this order:
  - start bit (0);
  - evt_chan, LSB first (2 bits);
  - evt_data, LSB first (8 bits);
  - parity bit: even parity over the 10 payload bits, i.e. the XOR of those 10 bits;
  - stop bit (1).
- FSM states: IDLE, START, PAYLOAD (10-bit counter), PARITY, STOP.
  - IDLE: if level>0, pop the head entry into the shift register, then go to START. Otherwise stay.
  - START → PAYLOAD → PARITY → STOP: each transition after BAUD_DIV cycles; PAYLOAD lasts 10 bit periods.
  - STOP → IDLE after BAUD_DIV cycles.
- A baud counter runs 0..BAUD_DIV−1 in every state except IDLE. It is cleared on entry to START.
- busy=1 in every state except IDLE.
- The frame payload is fixed at pop. FIFO activity during a frame never alters bits on the line.
- tx is driven from a register; there is no combinational path from any input to tx.

## Timing
- Push into an empty FIFO at edge k:
  - level=1 after edge k;
  - pop at edge k+1, so level=0, busy=1 and tx=0 after edge k+1.
- Frame duration is 13·BAUD_DIV cycles, measured from tx falling to the end of the stop bit.
- Back-to-back frames: after STOP there is exactly one IDLE cycle before the next START. The line is therefore high for BAUD_DIV+1 cycles between frames.
- fifo_full and level reflect registered state and change only on clock edges.
- Asserting rst_n low mid-frame takes effect immediately, without waiting for a clock edge:
  - tx=1, busy=0, FIFO empty, overflow=0;
  - the partial frame is abandoned and not retransmitted.
- Transmission restarts only after new events are pushed post-reset.

## Test plan
- All tests use BAUD_DIV=4 and DEPTH=4.
- Reset check: hold rst_n low, then release with no events → tx=1, busy=0, level=0, overflow=0 for 100 cycles.
- Single frame: one cycle of evt_valid with chan=2'b10, data=8'hA5 → tx falls 2 edges after the push edge. Bits, 4 cycles each: 0, 0,1, 1,0,1,0,0,1,0,1, 1, 1. busy falls after 52 cycles.
- Queue and spacing: push chan=0/data=8'h00, then chan=3/data=8'hFF on consecutive cycles. Expected:
  - first frame: start 0, payload all 0, parity 0, stop 1;
  - exactly 5 high cycles (stop bit plus one idle cycle) before the second start bit;
  - second frame parity=0, since the payload has ten 1s.
- Overflow: evt_valid high for 6 consecutive cycles with data 1..6 → data 1..5 are transmitted in order. Event 6 is dropped, overflow=1 and fifo_full=1 at that point.
- Overflow precedence: drop and clr_ovf in the same cycle → overflow stays 1. clr_ovf alone on the next cycle → overflow=0.
- Reset mid-operation: assert rst_n during the data bits of a frame with 2 entries queued → tx=1 and level=0 immediately. After release, no frames are sent until a new push.

Source files
------------

// File: rtl/change_event_tx.sv
// change_event_tx
//   Queues sensor change events ({chan, data}) in a small FIFO and sends each
//   one on a single serial pin as a 13-bit frame:
//   start(0), chan LSB-first, data LSB-first, even parity over the 10 payload
//   bits, stop(1). Every bit is held for BAUD_DIV clock cycles.
//   Overflow is flagged (sticky) instead of back-pressuring the producer.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   evt_valid  event strobe, one event per high cycle
//   evt_chan   channel index of the event
//   evt_data   new channel value
//   clr_ovf    synchronous clear of the overflow flag
//   tx         serial line, idle high, registered
//   busy       high while a frame is on the line
//   fifo_full  level == DEPTH
//   level      number of queued entries
//   overflow   sticky: at least one event was dropped
module change_event_tx #(
  parameter int DEPTH    = 4,
  parameter int BAUD_DIV = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     evt_valid,
  input  logic [1:0]               evt_chan,
  input  logic [7:0]               evt_data,
  input  logic                     clr_ovf,
  output logic                     tx,
  output logic                     busy,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_PAYLOAD,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  // Entry layout {data, chan}: bit 0 is the first payload bit on the line.
  logic [9:0]    fifo_mem [DEPTH];

  logic          pop;
  logic          push;
  logic          drop;
  logic          baud_end;
  logic [9:0]    head;

  // FIFO control. A full FIFO still accepts an event when the head is
  // popped in the same cycle.
  always_comb begin
    pop  = (state_q == S_IDLE) && (level_q != '0);
    push = evt_valid && ((level_q != LVL_FULL) || pop);
    drop = evt_valid && !push;
    head = fifo_mem[rd_ptr_q];

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)
      overflow_d = 1'b1;
    else if (clr_ovf)
      overflow_d = 1'b0;
    else
      overflow_d = overflow_q;
  end

  // Transmit FSM. tx_d/busy_d are computed for the state being entered so the
  // line and busy flag come straight from flops.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    baud_end = (baud_q == BAUD_LAST);

    if (state_q != S_IDLE)
      baud_d = baud_end ? '0 : baud_q + BW'(1);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          // Payload and parity are latched here, so later FIFO traffic
          // cannot disturb the frame in flight.
          state_d  = S_START;
          baud_d   = '0;
          shreg_d  = head;
          parity_d = ^head;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_PAYLOAD;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[9:1]};
        end
      end
      S_PAYLOAD: begin
        if (baud_end) begin
          if (bit_q == 4'd9) begin
            state_d = S_PARITY;
            tx_d    = parity_q;
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[9:1]};
          end
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: level/pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_q] <= {evt_data, evt_chan};
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign level     = level_q;
  assign fifo_full = (level_q == LVL_FULL);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_change_event_tx.sv
module tb_change_event_tx;

  localparam int DEPTH     = 4;
  localparam int BAUD_DIV  = 4;
  localparam int FRAME_CYC = 13 * BAUD_DIV;
  localparam int B2B_CYC   = FRAME_CYC + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       evt_valid = 1'b0;
  logic [1:0] evt_chan = 2'b00;
  logic [7:0] evt_data = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic [2:0] level;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_active = 1'b0;

  typedef struct {
    logic [12:0] frame;
    bit          b2b;
  } exp_t;

  exp_t exp_q[$];

  change_event_tx #(
    .DEPTH(DEPTH),
    .BAUD_DIV(BAUD_DIV)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .evt_valid(evt_valid),
    .evt_chan(evt_chan),
    .evt_data(evt_data),
    .clr_ovf(clr_ovf),
    .tx(tx),
    .busy(busy),
    .fifo_full(fifo_full),
    .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Frame bit i is the i-th bit on the line (index 0 = start bit).
  function automatic logic [12:0] mk_frame(input logic [1:0] ch, input logic [7:0] d);
    logic [12:0] f;
    int ones;
    ones = 0;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      f[1 + i] = ch[i];
      if (ch[i]) ones++;
    end
    for (int i = 0; i < 8; i++) begin
      f[3 + i] = d[i];
      if (d[i]) ones++;
    end
    f[11] = (ones % 2) == 1;
    f[12] = 1'b1;
    return f;
  endfunction

  // Drive one event for one clock edge; returns at the following negedge.
  task automatic push_evt(input logic [1:0] ch, input logic [7:0] d,
                          input bit expect_tx, input bit b2b, input logic [12:0] f);
    exp_t e;
    evt_valid = 1'b1;
    evt_chan  = ch;
    evt_data  = d;
    if (expect_tx) begin
      e.frame = f;
      e.b2b   = b2b;
      exp_q.push_back(e);
    end
    @(negedge clk);
    evt_valid = 1'b0;
    $display("push chan=%0d data=%02h expect_tx=%0d", ch, d, expect_tx);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic quiet_check(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || level !== 3'd0 || overflow !== 1'b0)
        bad++;
    end
    check(name, bad, 0);
  endtask

  // Monitor: captures every frame on tx and compares it against the
  // scoreboard queue filled by the stimulus.
  initial begin
    logic [12:0] cap;
    bit glitch, busy_bad, aborted;
    int start_cyc, last_start;
    exp_t e;
    last_start = -1000;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        mon_active = 1'b1;
        cap = '0;
        glitch = 1'b0;
        busy_bad = 1'b0;
        aborted = 1'b0;
        start_cyc = cyc;
        for (int j = 0; j < FRAME_CYC; j++) begin
          if (j > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (j % BAUD_DIV == 0)
            cap[j / BAUD_DIV] = tx;
          else if (tx !== cap[j / BAUD_DIV])
            glitch = 1'b1;
          if (busy !== 1'b1) busy_bad = 1'b1;
        end
        if (!aborted) begin
          @(negedge clk);
          if (rst_n !== 1'b1) aborted = 1'b1;
        end
        if (aborted) begin
          $display("frame abandoned by reset at cycle %0d", cyc);
        end else begin
          check("idle_after_frame_busy", busy, 1'b0);
          check("idle_after_frame_tx", tx, 1'b1);
          check("frame_bit_stable", glitch, 1'b0);
          check("frame_busy_high", busy_bad, 1'b0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame got=%04h want=none", cap);
          end else begin
            e = exp_q.pop_front();
            $display("frame start=%0d got=%04h want=%04h", start_cyc, cap, e.frame);
            check("frame_bits", cap, e.frame);
            if (e.b2b)
              check("frame_spacing", start_cyc - last_start, B2B_CYC);
          end
          last_start = start_cyc;
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_level", level, 3'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_full", fifo_full, 1'b0);
    rst_n = 1'b1;
    quiet_check("rst_quiet_100");

    // Single frame, hand-computed bits 0,0,1,1,0,1,0,0,1,0,1,1,1
    push_evt(2'b10, 8'hA5, 1'b1, 1'b0, 13'b1_1101_0010_1100);
    check("single_level_after_push", level, 3'd1);
    check("single_tx_before_pop", tx, 1'b1);
    check("single_busy_before_pop", busy, 1'b0);
    @(negedge clk);
    check("single_tx_start", tx, 1'b0);
    check("single_busy_start", busy, 1'b1);
    check("single_level_after_pop", level, 3'd0);
    wait_drain("single_drain");

    // Queue and spacing
    push_evt(2'd0, 8'h00, 1'b1, 1'b0, 13'h1000);
    push_evt(2'd3, 8'hFF, 1'b1, 1'b1, 13'h17FE);
    wait_drain("queue_drain");

    // Overflow: six back-to-back events, sixth is dropped
    for (int d = 1; d <= 6; d++)
      push_evt(2'd1, 8'(d), d <= 5, d > 1, mk_frame(2'd1, 8'(d)));
    check("ovf_overflow", overflow, 1'b1);
    check("ovf_full", fifo_full, 1'b1);
    check("ovf_level", level, 3'd4);

    // Drop and clear together: set wins
    clr_ovf = 1'b1;
    push_evt(2'd2, 8'h77, 1'b0, 1'b0, 13'h0);
    clr_ovf = 1'b0;
    check("prec_set_wins", overflow, 1'b1);
    check("prec_level", level, 3'd4);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("prec_clear", overflow, 1'b0);
    wait_drain("ovf_drain");

    // Reset mid-frame with two entries queued
    push_evt(2'd0, 8'h00, 1'b1, 1'b0, 13'h1000);
    push_evt(2'd1, 8'h11, 1'b1, 1'b1, mk_frame(2'd1, 8'h11));
    push_evt(2'd2, 8'h22, 1'b1, 1'b1, mk_frame(2'd2, 8'h22));
    check("mid_level_queued", level, 3'd2);
    repeat (16) @(negedge clk);
    check("mid_tx_before_rst", tx, 1'b0);
    check("mid_busy_before_rst", busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_level", level, 3'd0);
    check("mid_rst_overflow", overflow, 1'b0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet_check("mid_quiet_100");

    // Transmission resumes after a fresh push
    push_evt(2'd1, 8'h5A, 1'b1, 1'b0, mk_frame(2'd1, 8'h5A));
    wait_drain("restart_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
